// File: rtl/elevator_pkg.sv
package elevator_pkg;

  localparam logic [1:0] F1 = 2'b00;
  localparam logic [1:0] F2 = 2'b01;
  localparam logic [1:0] F3 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_MOVING,
    ST_HALT
  } state_e;

  // True when some pending call lies strictly beyond `floor` in direction `dir`.
  function automatic logic pending_ahead(input logic [2:0] leds,
                                         input logic [1:0] floor,
                                         input logic       dir);
    logic [2:0] above;
    logic [2:0] below;
    case (floor)
      F1:      begin above = 3'b110; below = 3'b000; end
      F2:      begin above = 3'b100; below = 3'b001; end
      default: begin above = 3'b000; below = 3'b011; end
    endcase
    return (dir == DIR_UP) ? |(leds & above) : |(leds & below);
  endfunction

endpackage

// File: rtl/door_timer.sv
module door_timer #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TICKS + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(TICKS);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/call_scheduler.sv
module call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  input  logic       step_ack,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] cur_floor,
  output logic       step_req,
  output logic       step_dir,
  output logic       moving,
  output logic       door_open
);

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic       dir_q, dir_d;
  logic [2:0] led_q, led_d;
  logic       req_q, req_d;
  logic       sdir_q, sdir_d;
  logic       moving_q, door_q;

  logic       t_load, t_dec, t_expired;
  logic [2:0] btn, cur_oh, nxt_oh, arrive_calls;
  logic [1:0] nxt_floor;
  logic       cur_press, new_dir;

  assign btn          = {button3, button2, button1};
  assign cur_oh       = 3'b001 << floor_q;
  assign cur_press    = |(btn & cur_oh);
  assign nxt_floor    = (sdir_q == DIR_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
  assign nxt_oh       = 3'b001 << nxt_floor;
  // A press landing together with the ack at that floor is treated as already served.
  assign arrive_calls = led_q | btn;
  assign new_dir      = pending_ahead(led_q, floor_q, dir_q) ? dir_q : ~dir_q;

  door_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (t_load),
    .dec_i     (t_dec),
    .expired_o (t_expired)
  );

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    led_d   = led_q;
    req_d   = req_q;
    sdir_d  = sdir_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d = led_q | (btn & ~cur_oh);
        if (sos_mode) begin
          state_d = ST_HALT;
        end else if (weight_limit_exceeded || cur_press) begin
          state_d = ST_OPEN;
          t_load  = 1'b1;
        end else if (|led_q) begin
          dir_d   = new_dir;
          sdir_d  = new_dir;
          req_d   = 1'b1;
          state_d = ST_MOVING;
        end
      end
      ST_MOVING: begin
        led_d = arrive_calls;
        if (step_ack) begin
          floor_d = nxt_floor;
          if (|(arrive_calls & nxt_oh)) begin
            led_d   = arrive_calls & ~nxt_oh;
            req_d   = 1'b0;
            state_d = ST_OPEN;
            t_load  = 1'b1;
          end else if (sos_mode) begin
            req_d   = 1'b0;
            state_d = ST_HALT;
          end
        end
      end
      ST_OPEN: begin
        led_d = led_q | (btn & ~cur_oh);
        if (weight_limit_exceeded || cur_press) begin
          t_load = 1'b1;
        end else begin
          t_dec = 1'b1;
          if (t_expired) begin
            state_d = sos_mode ? ST_HALT : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (!sos_mode) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      floor_q  <= F1;
      dir_q    <= DIR_UP;
      led_q    <= '0;
      req_q    <= 1'b0;
      sdir_q   <= DIR_DOWN;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
      req_q    <= req_d;
      sdir_q   <= sdir_d;
      moving_q <= (state_d == ST_MOVING);
      door_q   <= (state_d == ST_OPEN) || (state_d == ST_HALT);
    end
  end

  assign led1      = led_q[0];
  assign led2      = led_q[1];
  assign led3      = led_q[2];
  assign cur_floor = floor_q;
  assign step_req  = req_q;
  assign step_dir  = sdir_q;
  assign moving    = moving_q;
  assign door_open = door_q;

  assert property (@(posedge clk) disable iff (reset)
    req_q |-> !((sdir_q == DIR_UP && floor_q == F3) || (sdir_q == DIR_DOWN && floor_q == F1)));

  assert property (@(posedge clk) disable iff (reset) floor_q != 2'b11);

endmodule

// File: tb/tb_call_scheduler.sv
module tb_call_scheduler;

  localparam int unsigned DT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       button1, button2, button3;
  logic       sos_mode, weight_limit_exceeded, step_ack;
  logic       led1, led2, led3;
  logic [1:0] cur_floor;
  logic       step_req, step_dir, moving, door_open;

  call_scheduler #(.DOOR_TICKS(DT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .button1               (button1),
    .button2               (button2),
    .button3               (button3),
    .sos_mode              (sos_mode),
    .weight_limit_exceeded (weight_limit_exceeded),
    .step_ack              (step_ack),
    .led1                  (led1),
    .led2                  (led2),
    .led3                  (led3),
    .cur_floor             (cur_floor),
    .step_req              (step_req),
    .step_dir              (step_dir),
    .moving                (moving),
    .door_open             (door_open)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_OPEN, M_MOVE, M_HALT} mstate_t;

  mstate_t m_state;
  int      m_floor, m_dir, m_sdir, m_timer;
  bit      m_led[3];
  bit      m_req;

  int total = 0;
  int bad   = 0;

  int req_age   = 0;
  int ack_lat   = 2;
  int poa_floor = -1;
  bit ack_block = 0;
  bit spurious  = 0;
  bit rand_lat  = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_floor = 0;
    m_dir   = 1;
    m_sdir  = -1;
    m_timer = 0;
    m_req   = 0;
    for (int f = 0; f < 3; f++) m_led[f] = 0;
  endfunction

  function automatic void model_step(input bit [2:0] b, input bit s, input bit w, input bit a);
    bit old[3];
    bit ahead;
    int nf;
    old   = m_led;
    ahead = 0;
    case (m_state)
      M_IDLE: begin
        for (int f = 0; f < 3; f++) if (b[f] && f != m_floor) m_led[f] = 1;
        if (s) begin
          m_state = M_HALT;
        end else if (w || b[m_floor]) begin
          m_state = M_OPEN;
          m_timer = DT;
        end else if (old[0] || old[1] || old[2]) begin
          for (int f = 0; f < 3; f++) if (old[f] && (f - m_floor) * m_dir > 0) ahead = 1;
          if (!ahead) m_dir = -m_dir;
          m_sdir  = m_dir;
          m_req   = 1;
          m_state = M_MOVE;
        end
      end
      M_MOVE: begin
        for (int f = 0; f < 3; f++) if (b[f]) m_led[f] = 1;
        if (a) begin
          nf      = m_floor + m_sdir;
          m_floor = nf;
          if (old[nf] || b[nf]) begin
            m_led[nf] = 0;
            m_req     = 0;
            m_state   = M_OPEN;
            m_timer   = DT;
          end else if (s) begin
            m_req   = 0;
            m_state = M_HALT;
          end
        end
      end
      M_OPEN: begin
        for (int f = 0; f < 3; f++) if (b[f] && f != m_floor) m_led[f] = 1;
        if (w || b[m_floor]) begin
          m_timer = DT;
        end else if (m_timer == 1) begin
          m_timer = 0;
          m_state = s ? M_HALT : M_IDLE;
        end else begin
          m_timer = m_timer - 1;
        end
      end
      default: begin
        if (!s) m_state = M_IDLE;
      end
    endcase
  endfunction

  task automatic compare_all();
    check_eq("leds", {5'b0, led3, led2, led1}, {5'b0, m_led[2], m_led[1], m_led[0]});
    check_eq("floor", {6'b0, cur_floor}, 8'(m_floor));
    check_eq("step_req", {7'b0, step_req}, {7'b0, m_req});
    check_eq("step_dir", {7'b0, step_dir}, {7'b0, (m_sdir > 0)});
    check_eq("moving", {7'b0, moving}, {7'b0, (m_state == M_MOVE)});
    check_eq("door_open", {7'b0, door_open}, {7'b0, (m_state == M_OPEN || m_state == M_HALT)});
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check.
  task automatic tick(input bit [2:0] b, input bit s, input bit w);
    bit [2:0] bb;
    bit       a;
    a  = 0;
    bb = b;
    if (m_req) begin
      if (!ack_block && req_age >= ack_lat) begin
        a       = 1;
        req_age = 0;
        if (rand_lat) ack_lat = $urandom_range(0, 3);
      end else begin
        req_age++;
      end
      if (a && poa_floor >= 0 && (m_floor + m_sdir) == poa_floor) begin
        bb[poa_floor] = 1;
        poa_floor     = -1;
      end
    end else begin
      req_age = 0;
      a       = spurious && ($urandom_range(0, 9) == 0);
    end
    button1               = bb[0];
    button2               = bb[1];
    button3               = bb[2];
    sos_mode              = s;
    weight_limit_exceeded = w;
    step_ack              = a;
    @(posedge clk);
    model_step(bb, s, w, a);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_door(input string tag, input bit s);
    for (int i = 0; i < 40; i++) begin
      if (door_open) break;
      tick(3'b000, s, 1'b0);
    end
    check_eq({tag, "_door_reached"}, {7'b0, door_open}, 8'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (step_req) break;
      tick(3'b000, 1'b0, 1'b0);
    end
    check_eq({tag, "_req_reached"}, {7'b0, step_req}, 8'd1);
  endtask

  task automatic count_door(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!door_open) break;
      n++;
      tick(3'b000, 1'b0, 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_leds"}, {5'b0, led3, led2, led1}, 8'd0);
    check_eq({tag, "_floor"}, {6'b0, cur_floor}, 8'd0);
    check_eq({tag, "_req"}, {7'b0, step_req}, 8'd0);
    check_eq({tag, "_dir"}, {7'b0, step_dir}, 8'd0);
    check_eq({tag, "_moving"}, {7'b0, moving}, 8'd0);
    check_eq({tag, "_door"}, {7'b0, door_open}, 8'd0);
  endtask

  initial begin
    int n, dc;
    bit [2:0] rb;
    bit rs, rw;

    reset = 1'b1;
    button1 = 0; button2 = 0; button3 = 0;
    sos_mode = 0; weight_limit_exceeded = 0; step_ack = 0;
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;

    // Press 3 from F1: pass F2 without stopping, dwell at F3.
    tick(3'b100, 1'b0, 1'b0);
    check_eq("s1_led3_set", {7'b0, led3}, 8'd1);
    wait_door("s1", 1'b0);
    check_eq("s1_at_f3", {6'b0, cur_floor}, 8'd2);
    check_eq("s1_led3_clr", {7'b0, led3}, 8'd0);
    count_door(n);
    check_eq("s1_dwell", 8'(n), 8'd4);

    // From F3 press 1 and 2: reverse, stop at F2, then F1.
    tick(3'b011, 1'b0, 1'b0);
    wait_door("s2a", 1'b0);
    check_eq("s2_at_f2", {6'b0, cur_floor}, 8'd1);
    check_eq("s2_led2_clr", {7'b0, led2}, 8'd0);
    check_eq("s2_led1_kept", {7'b0, led1}, 8'd1);
    check_eq("s2_dir_down", {7'b0, step_dir}, 8'd0);
    count_door(n);
    check_eq("s2_dwell_f2", 8'(n), 8'd4);
    wait_door("s2b", 1'b0);
    check_eq("s2_at_f1", {6'b0, cur_floor}, 8'd0);
    count_door(n);

    // Overload holds the door at F1 with F2 pending.
    tick(3'b010, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(3'b000, 1'b0, 1'b1);
      check_eq("s3_door_held", {7'b0, door_open}, 8'd1);
      check_eq("s3_no_req", {7'b0, step_req}, 8'd0);
    end
    n = 0;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (step_req) break;
      if (door_open) dc++;
      n++;
      tick(3'b000, 1'b0, 1'b0);
    end
    check_eq("s3_door_after_release", 8'(dc), 8'd4);
    check_eq("s3_cycles_to_req", 8'(n), 8'd5);
    wait_door("s3", 1'b0);
    check_eq("s3_at_f2", {6'b0, cur_floor}, 8'd1);
    count_door(n);

    tick(3'b001, 1'b0, 1'b0);
    wait_door("back_f1", 1'b0);
    count_door(n);

    // Press 2 in the same cycle the ack lands at F2.
    poa_floor = 1;
    tick(3'b100, 1'b0, 1'b0);
    wait_door("s5a", 1'b0);
    check_eq("s5_at_f2", {6'b0, cur_floor}, 8'd1);
    check_eq("s5_led2_off", {7'b0, led2}, 8'd0);
    check_eq("s5_led3_kept", {7'b0, led3}, 8'd1);
    count_door(n);
    check_eq("s5_dwell_once", 8'(n), 8'd4);
    wait_door("s5b", 1'b0);
    check_eq("s5_at_f3", {6'b0, cur_floor}, 8'd2);
    count_door(n);

    // SOS mid-step: request held until ack, then HALT at F2.
    tick(3'b001, 1'b0, 1'b0);
    ack_block = 1;
    wait_req("s4");
    for (int i = 0; i < 3; i++) begin
      tick(3'b000, 1'b1, 1'b0);
      check_eq("s4_req_held", {7'b0, step_req}, 8'd1);
    end
    ack_block = 0;
    wait_door("s4", 1'b1);
    check_eq("s4_halt_f2", {6'b0, cur_floor}, 8'd1);
    check_eq("s4_halt_noreq", {7'b0, step_req}, 8'd0);
    check_eq("s4_led1_kept", {7'b0, led1}, 8'd1);
    tick(3'b100, 1'b1, 1'b0);
    check_eq("s4_btn_ignored", {7'b0, led3}, 8'd0);
    tick(3'b000, 1'b0, 1'b0);
    check_eq("s4_idle_door", {7'b0, door_open}, 8'd0);
    wait_door("s4_resume", 1'b0);
    check_eq("s4_at_f1", {6'b0, cur_floor}, 8'd0);
    count_door(n);

    // Reset while moving.
    tick(3'b100, 1'b0, 1'b0);
    ack_block = 1;
    wait_req("s6");
    tick(3'b000, 1'b0, 1'b0);
    check_eq("s6_moving", {7'b0, moving}, 8'd1);
    #2;
    reset = 1'b1;
    step_ack = 1'b0;
    button3 = 1'b0;
    #1;
    check_reset_values("s6_async");
    model_reset();
    req_age   = 0;
    ack_block = 0;
    @(negedge clk);
    reset = 1'b0;
    compare_all();

    // Randomized traffic against the model.
    spurious = 1;
    rand_lat = 1;
    rs = 0;
    rw = 0;
    for (int i = 0; i < 3000; i++) begin
      rb = 3'($urandom) & 3'($urandom) & 3'($urandom);
      if ($urandom_range(0, 39) == 0) rs = ~rs;
      if ($urandom_range(0, 29) == 0) rw = ~rw;
      tick(rb, rs, rw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
